tone_gen: RTL and testbench
===========================

// Module: tone_gen
// PURPOSE
//   Audio note generator. Sits directly downstream of the control unit: takes the
//   note code control produces plus a one-cycle strobe, and plays a square-wave tone.
//   Each note lasts C_MUSIC ms, followed by a silent gap of C_GAP ms.
//   The 1-bit output drives the board audio/PWM pin.
// PARAMETERS
//   C_CLK_FRQ          100_000_000  clock frequency [Hz]
//   C_MUSIC            500          note duration [ms]
//   C_GAP              20           silent gap after each note [ms]
//   C_UART_DATA_WIDTH  8            note code width [bit], >= 6
// PORTS
//   clk       in   1        system clock
//   rstb      in   1        synchronous reset, active low
//   inNote    in   C_UART_DATA_WIDTH  note code from control; [3:0]=semitone, [5:4]=octave, upper bits ignored
//   inValid   in   1        1-cycle strobe; inNote valid in the same cycle
//   outAudio  out  1        square-wave audio
//   outBusy   out  1        high in PLAY and GAP
//   outNote   out  6        code currently playing ({octave,semitone})
// BEHAVIOUR
// - Reset is synchronous. While rstb=0 at a clk edge: state=IDLE, all counters=0,
//   outAudio=0, outBusy=0, outNote=0. Reset mid-note aborts the note immediately.
// - Half-period table, fixed at elaboration: H[s] = C_CLK_FRQ*50 / F[s], integer floor.
//   F is in centi-Hz, semitones 0..11 = C4..B4:
//   26163 27718 29366 31113 32963 34923 36999 39200 41530 44000 46616 49388.
//   Effective half period Heff = H[s] >> oct.
//   Semitone 12..15 is a REST: full duration, outAudio held 0.
// - D = (C_CLK_FRQ/1000)*C_MUSIC cycles. G = (C_CLK_FRQ/1000)*C_GAP cycles.
//   Counters are sized for D and for H[0].
// - FSM states: IDLE, PLAY, GAP.
//   - IDLE --inValid--> PLAY.
//   - PLAY --D cycles elapsed--> GAP.
//   - GAP --G cycles elapsed--> IDLE.
//   - If G=0, PLAY goes directly to IDLE.
// - Start: at the edge where inValid=1 is sampled:
//   - state=PLAY, outNote=inNote[5:0], duration counter cleared;
//   - outAudio=1, or 0 for a REST.
//   Latency from strobe to first audio edge is 1 cycle.
// - PLAY: outAudio toggles every Heff cycles. First toggle comes Heff cycles after start.
//   The PLAY->GAP edge occurs exactly D cycles after start.
//   At that edge outAudio is forced to 0, whatever its phase.
// - GAP: outAudio=0, outBusy=1, outNote holds its value. At GAP->IDLE, outNote is kept.
// - Retrigger: inValid in PLAY or GAP restarts immediately with the new code.
//   Duration and half-period counters reload; the rest follows the Start rule.
//   No queueing: a strobe during a note replaces it.
// - inValid in the same cycle as the PLAY->GAP or GAP->IDLE transition: the retrigger wins.
// - Simultaneous inValid and rstb=0: reset wins.
// - outBusy = (state != IDLE), registered, and changes on the same edge as state.
// - All outputs are registered. There are no combinational paths from inputs to outputs.
// TESTING
//   Bench parameters: C_CLK_FRQ=1_000_000, C_MUSIC=2, C_GAP=1. This gives D=2000, G=1000,
//   H[9](A4)=1136.
//   1. Strobe inNote=0x09 -> outAudio rises next cycle, toggles every 1136 cycles.
//      outAudio is 0 from cycle 2000, outBusy falls at cycle 3000.
//   2. inNote=0x19 (A5) -> toggles every 568 cycles. inNote=0x39 -> every 142 cycles.
//   3. inNote=0x0C (rest) -> outAudio=0 throughout, outBusy=1 for 3000 cycles.
//   4. Strobe 0x00, then strobe 0x09 at cycle 700 -> period switches immediately to 2*1136.
//      outBusy stays high until cycle 3700.
//   5. rstb=0 for 1 cycle at cycle 500 of a note -> next cycle outAudio=0, outBusy=0,
//      outNote=0, and the block is idle.
//   6. Strobe on the exact cycle PLAY ends (cycle 2000) -> new note starts, no GAP entered.

Source files
------------

// File: rtl/tone_gen.sv
// ---------------------------------------------------------------------------
// tone_gen
//   Square-wave note player fed by the control unit. A one-cycle strobe
//   latches a 6-bit note code ({octave, semitone}) and plays it for C_MUSIC ms.
//   A silent gap of C_GAP ms follows. A new strobe at any time replaces the
//   current note. Semitones 12..15 are rests: full duration, output held low.
//
// Ports
//   clk       in   1                  system clock
//   rstb      in   1                  synchronous reset, active low
//   inNote    in   C_UART_DATA_WIDTH  [3:0]=semitone, [5:4]=octave, rest ignored
//   inValid   in   1                  one-cycle strobe qualifying inNote
//   outAudio  out  1                  square-wave audio (registered)
//   outBusy   out  1                  high while playing or in the gap (registered)
//   outNote   out  6                  code currently / last played (registered)
// ---------------------------------------------------------------------------
module tone_gen #(
    parameter int C_CLK_FRQ         = 32'd100_000_000,
    parameter int C_MUSIC           = 32'd500,
    parameter int C_GAP             = 32'd20,
    parameter int C_UART_DATA_WIDTH = 32'd8
) (
    input  logic                         clk,
    input  logic                         rstb,
    input  logic [C_UART_DATA_WIDTH-1:0] inNote,
    input  logic                         inValid,
    output logic                         outAudio,
    output logic                         outBusy,
    output logic [5:0]                   outNote
);

    // Cycle budgets for the note and the trailing gap.
    localparam longint unsigned CYC_PER_MS = 64'(C_CLK_FRQ) / 64'd1000;
    localparam longint unsigned DUR_CYC    = CYC_PER_MS * 64'(C_MUSIC);
    localparam longint unsigned GAP_CYC    = CYC_PER_MS * 64'(C_GAP);
    localparam longint unsigned CNT_MAX    = (DUR_CYC > GAP_CYC) ? DUR_CYC : GAP_CYC;
    localparam int              DW         = $clog2(CNT_MAX + 64'd1);
    localparam bit              HAS_GAP    = (GAP_CYC != 64'd0);

    // Half-period numerator: frequencies below are in centi-Hz.
    localparam longint unsigned CLK_HALF = 64'(C_CLK_FRQ) * 64'd50;
    localparam longint unsigned H_MAX    = CLK_HALF / 64'd26163;
    localparam int              HW       = $clog2(H_MAX + 64'd1);

    localparam logic [DW-1:0] D_ZERO   = {DW{1'b0}};
    localparam logic [DW-1:0] D_ONE    = {{(DW-1){1'b0}}, 1'b1};
    localparam logic [DW-1:0] DUR_LAST = DW'(DUR_CYC - 64'd1);
    localparam logic [DW-1:0] GAP_LAST = DW'(GAP_CYC - 64'd1);
    localparam logic [HW-1:0] H_ZERO   = {HW{1'b0}};
    localparam logic [HW-1:0] H_ONE    = {{(HW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Octave-0 half period (C4..B4) in clock cycles; rests return zero.
    function automatic logic [HW-1:0] half_period(input logic [3:0] semi);
        logic [HW-1:0] h;
        case (semi)
            4'd0:    h = HW'(CLK_HALF / 64'd26163);
            4'd1:    h = HW'(CLK_HALF / 64'd27718);
            4'd2:    h = HW'(CLK_HALF / 64'd29366);
            4'd3:    h = HW'(CLK_HALF / 64'd31113);
            4'd4:    h = HW'(CLK_HALF / 64'd32963);
            4'd5:    h = HW'(CLK_HALF / 64'd34923);
            4'd6:    h = HW'(CLK_HALF / 64'd36999);
            4'd7:    h = HW'(CLK_HALF / 64'd39200);
            4'd8:    h = HW'(CLK_HALF / 64'd41530);
            4'd9:    h = HW'(CLK_HALF / 64'd44000);
            4'd10:   h = HW'(CLK_HALF / 64'd46616);
            4'd11:   h = HW'(CLK_HALF / 64'd49388);
            default: h = H_ZERO;
        endcase
        return h;
    endfunction

    state_t          state_r,    state_s;
    logic [DW-1:0]   dur_cnt_r,  dur_cnt_s;   // PLAY: note elapsed, GAP: gap elapsed
    logic [HW-1:0]   half_cnt_r, half_cnt_s;
    logic [HW-1:0]   heff_r,     heff_s;      // half period after octave shift
    logic            rest_r,     rest_s;
    logic            audio_r,    audio_s;
    logic            busy_r,     busy_s;
    logic [5:0]      note_r,     note_s;

    // Code bits above the octave field carry no meaning here.
    generate
        if (C_UART_DATA_WIDTH > 6) begin : g_upper
            logic unused_upper_s;
            assign unused_upper_s = ^inNote[C_UART_DATA_WIDTH-1:6];
        end
    endgenerate

    // Next-state and next-output logic; a strobe overrides every state.
    always_comb begin
        state_s    = state_r;
        dur_cnt_s  = dur_cnt_r;
        half_cnt_s = half_cnt_r;
        heff_s     = heff_r;
        rest_s     = rest_r;
        audio_s    = audio_r;
        busy_s     = busy_r;
        note_s     = note_r;

        if (inValid) begin
            state_s    = PLAY;
            dur_cnt_s  = D_ZERO;
            half_cnt_s = H_ZERO;
            heff_s     = half_period(inNote[3:0]) >> inNote[5:4];
            rest_s     = (inNote[3:2] == 2'b11);
            audio_s    = (inNote[3:2] != 2'b11);
            busy_s     = 1'b1;
            note_s     = inNote[5:0];
        end else begin
            case (state_r)
                IDLE: begin
                    audio_s = 1'b0;
                    busy_s  = 1'b0;
                end
                PLAY: begin
                    if (dur_cnt_r == DUR_LAST) begin
                        // Note over: silence regardless of current phase.
                        audio_s    = 1'b0;
                        dur_cnt_s  = D_ZERO;
                        half_cnt_s = H_ZERO;
                        if (HAS_GAP) begin
                            state_s = GAP;
                            busy_s  = 1'b1;
                        end else begin
                            state_s = IDLE;
                            busy_s  = 1'b0;
                        end
                    end else begin
                        dur_cnt_s = dur_cnt_r + D_ONE;
                        if (rest_r) begin
                            audio_s    = 1'b0;
                            half_cnt_s = H_ZERO;
                        end else if (half_cnt_r == heff_r - H_ONE) begin
                            audio_s    = ~audio_r;
                            half_cnt_s = H_ZERO;
                        end else begin
                            half_cnt_s = half_cnt_r + H_ONE;
                        end
                    end
                end
                GAP: begin
                    audio_s = 1'b0;
                    if (dur_cnt_r == GAP_LAST) begin
                        state_s   = IDLE;
                        busy_s    = 1'b0;
                        dur_cnt_s = D_ZERO;
                    end else begin
                        dur_cnt_s = dur_cnt_r + D_ONE;
                    end
                end
                default: begin
                    state_s    = IDLE;
                    dur_cnt_s  = D_ZERO;
                    half_cnt_s = H_ZERO;
                    audio_s    = 1'b0;
                    busy_s     = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_r    <= IDLE;
            dur_cnt_r  <= D_ZERO;
            half_cnt_r <= H_ZERO;
            heff_r     <= H_ZERO;
            rest_r     <= 1'b0;
            audio_r    <= 1'b0;
            busy_r     <= 1'b0;
            note_r     <= 6'd0;
        end else begin
            state_r    <= state_s;
            dur_cnt_r  <= dur_cnt_s;
            half_cnt_r <= half_cnt_s;
            heff_r     <= heff_s;
            rest_r     <= rest_s;
            audio_r    <= audio_s;
            busy_r     <= busy_s;
            note_r     <= note_s;
        end
    end

    assign outAudio = audio_r;
    assign outBusy  = busy_r;
    assign outNote  = note_r;

endmodule

// File: tb/tb_tone_gen.sv
// ---------------------------------------------------------------------------
// tb_tone_gen
//   A reference model predicts, for every clock edge, what the three outputs
//   must be after that edge, from the time elapsed since the last accepted
//   strobe. Predictions go into a queue; a monitor pops one per cycle and
//   compares it with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_tone_gen;

    localparam int CLK = 1_000_000;
    localparam int MUS = 2;
    localparam int GP  = 1;
    localparam int W   = 8;
    localparam longint D = (CLK / 1000) * MUS;
    localparam longint G = (CLK / 1000) * GP;

    logic         clk     = 1'b0;
    logic         rstb    = 1'b0;
    logic         inValid = 1'b0;
    logic [W-1:0] inNote  = '0;
    logic         outAudio;
    logic         outBusy;
    logic [5:0]   outNote;

    tone_gen #(
        .C_CLK_FRQ(CLK),
        .C_MUSIC(MUS),
        .C_GAP(GP),
        .C_UART_DATA_WIDTH(W)
    ) dut (
        .clk(clk),
        .rstb(rstb),
        .inNote(inNote),
        .inValid(inValid),
        .outAudio(outAudio),
        .outBusy(outBusy),
        .outNote(outNote)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       audio;
        logic       busy;
        logic [5:0] note;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    int freq_ch [12] = '{26163, 27718, 29366, 31113, 32963, 34923,
                         36999, 39200, 41530, 44000, 46616, 49388};

    // Model state: note start edge, code, whether anything was started.
    longint     edge_n = 0;
    longint     t0     = 0;
    bit         active = 1'b0;
    logic [5:0] m_note = 6'd0;

    function automatic exp_t predict(longint k, logic [5:0] code, bit act);
        exp_t   e;
        longint heff;
        e.note  = code;
        e.audio = 1'b0;
        e.busy  = 1'b0;
        if (act) begin
            if (k < D) begin
                e.busy = 1'b1;
                if (code[3:0] < 4'd12) begin
                    heff    = (longint'(CLK) * 50 / freq_ch[code[3:0]]) >> code[5:4];
                    e.audio = ((k / heff) % 2 == 0);
                end
            end else if (k < D + G) begin
                e.busy = 1'b1;
            end
        end
        return e;
    endfunction

    // Reference model: decide what the edge does, push the prediction.
    always @(posedge clk) begin
        edge_n++;
        if (!rstb) begin
            active = 1'b0;
            m_note = 6'd0;
        end else if (inValid) begin
            active = 1'b1;
            t0     = edge_n;
            m_note = inNote[5:0];
        end
        exp_q.push_back(predict(edge_n - t0, m_note, active));
    end

    // Monitor: compare DUT outputs shortly after each edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            vectors++;
            if ({outAudio, outBusy, outNote} !== e) begin
                miscompares++;
                $display("FAIL outputs edge=%0d: got audio=%b busy=%b note=%h, want audio=%b busy=%b note=%h",
                         edge_n, outAudio, outBusy, outNote, e.audio, e.busy, e.note);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge: present a strobe for exactly one edge.
    task automatic strobe(input logic [W-1:0] c);
        inNote  = c;
        inValid = 1'b1;
        @(negedge clk);
        inValid = 1'b0;
        inNote  = W'($urandom);
    endtask

    task automatic rst_pulse(input bit with_valid);
        rstb    = 1'b0;
        inValid = with_valid;
        inNote  = 8'h19;
        @(negedge clk);
        rstb    = 1'b1;
        inValid = 1'b0;
    endtask

    initial begin
        idle(3);
        rstb = 1'b1;
        idle(2);

        strobe(8'h09); idle(3100);          // A4, full note + gap + idle
        strobe(8'h19); idle(3100);          // A5
        strobe(8'hB9); idle(3100);          // A7, upper bits ignored
        strobe(8'h0C); idle(3100);          // rest
        strobe(8'h00); idle(699);           // retrigger at cycle 700
        strobe(8'h09); idle(3100);
        strobe(8'h09); idle(499);           // reset mid-note
        rst_pulse(1'b0); idle(50);
        strobe(8'h2B); idle(300);           // reset wins over strobe
        rst_pulse(1'b1); idle(50);
        strobe(8'h15); idle(1999);          // strobe exactly at end of PLAY
        strobe(8'h2A); idle(2500);          // strobe during GAP
        strobe(8'h37); idle(3100);

        for (int i = 0; i < 20; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0) begin
                rst_pulse(1'b0);
            end else if (r == 1) begin
                rst_pulse(1'b1);
            end else begin
                strobe(W'($urandom_range(0, 255)));
            end
            idle($urandom_range(1, 3500));
        end

        idle(3100);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending predictions, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
